// File: rtl/ecc_csr_pkg.sv
// Shared constants for the ECC CSR master: CSR word map, control bit positions, FSM encoding
// and the operand-to-bus-word packing rule.
package ecc_csr_pkg;

  localparam logic [4:0] CSR_CTRL = 5'd0;
  localparam logic [4:0] CSR_K    = 5'd1;
  localparam logic [4:0] CSR_PY   = 5'd7;
  localparam logic [4:0] CSR_PX   = 5'd13;
  localparam logic [4:0] CSR_PUX  = 5'd20;
  localparam logic [4:0] CSR_PUY  = 5'd26;

  localparam int ECC1_GO   = 0;
  localparam int ECC1_DONE = 31;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WR_OPND   = 3'd1;
  localparam state_t S_WR_GO     = 3'd2;
  localparam state_t S_POLL_RD   = 3'd3;
  localparam state_t S_POLL_WAIT = 3'd4;
  localparam state_t S_RD_RES    = 3'd5;
  localparam state_t S_RD_WAIT   = 3'd6;
  localparam state_t S_CLR_GO    = 3'd7;

  // Word w of a 164-bit operand, MSB first; word 5 carries v[3:0] in its top nibble.
  function automatic logic [31:0] pack_word(input logic [163:0] v, input logic [2:0] w);
    logic [191:0] t;
    t = {v, 28'h0};
    return t[191 - 32*w -: 32];
  endfunction

endpackage

// File: rtl/ecc_csr_master_avmm_xact.sv
// Single-transaction Avalon-MM engine: accepts one read or write request while idle and
// reports completion on ack (write accepted by the slave, or read data returned).
module avmm_xact
  import ecc_csr_pkg::*;
#(
  parameter int AW = 26,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          idle,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] master_address,
  output logic [DW-1:0] master_writedata,
  output logic          master_write,
  output logic          master_read,
  input  logic [DW-1:0] master_readdata,
  input  logic          master_readdatavalid,
  input  logic          master_waitrequest
);

  // Handshake: address/data/strobe are registered and held while waitrequest=1; a cycle with
  // strobe=1 and waitrequest=0 completes the command and the strobe drops on the next edge.
  // A read then waits in pend for exactly one readdatavalid; valid without pend is dropped.
  logic pend;

  assign idle  = !master_write && !master_read && !pend;
  assign ack   = (master_write && !master_waitrequest) || (pend && master_readdatavalid);
  assign rdata = master_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      master_address   <= '0;
      master_writedata <= '0;
      master_write     <= 1'b0;
      master_read      <= 1'b0;
      pend             <= 1'b0;
    end else begin
      if (idle && req) begin
        master_address   <= addr;
        master_writedata <= wdata;
        master_write     <= we;
        master_read      <= !we;
      end
      if (master_write && !master_waitrequest) master_write <= 1'b0;
      if (master_read && !master_waitrequest) begin
        master_read <= 1'b0;
        pend        <= 1'b1;
      end
      if (pend && master_readdatavalid) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ecc_csr_master.sv
// Avalon-MM master that loads k/PX/PY into the ECC CSR slave, starts ECC1, polls for done
// and reads PuX/PuY back, replacing the host software sequence.
module ecc_csr_master
  import ecc_csr_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH = 32,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] SLAVE_BASE = '0,
  parameter int POLL_LIMIT = 100000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [163:0]                   k,
  input  logic [163:0]                   px,
  input  logic [163:0]                   py,
  output logic [163:0]                   pux,
  output logic [163:0]                   puy,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [2:0]                     state_dbg,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest
);

  state_t         state;
  logic [4:0]     idx;
  logic [31:0]    poll_cnt;
  logic           err;
  logic [163:0]   k_r, px_r, py_r, res_x, res_y;
  logic           req, we, xact_idle, ack;
  logic [4:0]     req_idx;
  logic [DATAWIDTH-1:0] wdata, rdata;
  logic [163:0]   opnd;
  logic [2:0]     word_sel;

  assign state_dbg = state;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_CLR_GO) && ack && !err;
  assign timeout   = (state == S_CLR_GO) && ack && err;

  always_comb begin
    opnd     = px_r;
    word_sel = 3'(idx - CSR_PX);
    if (idx < CSR_PY) begin
      opnd     = k_r;
      word_sel = 3'(idx - CSR_K);
    end else if (idx < CSR_PX) begin
      opnd     = py_r;
      word_sel = 3'(idx - CSR_PY);
    end
  end

  // Requests are raised only while the engine is idle, so each state issues exactly one command.
  always_comb begin
    req     = 1'b0;
    we      = 1'b0;
    req_idx = idx;
    wdata   = '0;
    case (state)
      S_WR_OPND: begin req = xact_idle; we = 1'b1; wdata = pack_word(opnd, word_sel); end
      S_WR_GO:   begin req = xact_idle; we = 1'b1; req_idx = CSR_CTRL; wdata[ECC1_GO] = 1'b1; end
      S_POLL_RD: begin req = xact_idle; req_idx = CSR_CTRL; end
      S_RD_RES:  req = xact_idle;
      S_CLR_GO:  begin req = xact_idle; we = 1'b1; req_idx = CSR_CTRL; end
      default:   req = 1'b0;
    endcase
  end

  avmm_xact #(.AW(MASTER_ADDRESSWIDTH), .DW(DATAWIDTH)) u_xact (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req                  (req),
    .we                   (we),
    .addr                 (SLAVE_BASE + MASTER_ADDRESSWIDTH'({req_idx, 2'b00})),
    .wdata                (wdata),
    .idle                 (xact_idle),
    .ack                  (ack),
    .rdata                (rdata),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      poll_cnt <= '0;
      err      <= 1'b0;
      k_r      <= '0;
      px_r     <= '0;
      py_r     <= '0;
      res_x    <= '0;
      res_y    <= '0;
      pux      <= '0;
      puy      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          k_r      <= k;
          px_r     <= px;
          py_r     <= py;
          idx      <= CSR_K;
          poll_cnt <= '0;
          err      <= 1'b0;
          res_x    <= '0;
          res_y    <= '0;
          state    <= S_WR_OPND;
        end
        S_WR_OPND: if (ack) begin
          if (idx == CSR_PX + 5'd5) state <= S_WR_GO;
          else idx <= idx + 5'd1;
        end
        S_WR_GO: if (ack) state <= S_POLL_RD;
        S_POLL_RD: if (xact_idle) state <= S_POLL_WAIT;
        S_POLL_WAIT: if (ack) begin
          if (rdata[ECC1_DONE]) begin
            idx   <= CSR_PUX;
            state <= S_RD_RES;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
            if (poll_cnt + 32'd1 == 32'(POLL_LIMIT)) begin
              err   <= 1'b1;
              state <= S_CLR_GO;
            end else begin
              state <= S_POLL_RD;
            end
          end
        end
        S_RD_RES: if (xact_idle) state <= S_RD_WAIT;
        S_RD_WAIT: if (ack) begin
          // Results shift in MSB-first; the last word of each value contributes only its top nibble.
          if (idx == CSR_PUY - 5'd1)      res_x <= {res_x[159:0], rdata[31:28]};
          else if (idx < CSR_PUY)         res_x <= {res_x[131:0], rdata[31:0]};
          else if (idx == CSR_PUY + 5'd5) res_y <= {res_y[159:0], rdata[31:28]};
          else                            res_y <= {res_y[131:0], rdata[31:0]};
          if (idx == CSR_PUY + 5'd5) state <= S_CLR_GO;
          else begin
            idx   <= idx + 5'd1;
            state <= S_RD_RES;
          end
        end
        S_CLR_GO: if (ack) begin
          state <= S_IDLE;
          if (!err) begin
            pux <= res_x;
            puy <= res_y;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_csr_master.sv
// Directed bench for ecc_csr_master against a small Avalon-MM CSR slave model.
module tb_ecc_csr_master;
  import ecc_csr_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [163:0] k, px, py, pux, puy;
  logic         busy, done, timeout;
  logic [2:0]   state_dbg;
  logic [25:0]  master_address;
  logic [31:0]  master_writedata;
  logic         master_write, master_read;
  logic [31:0]  master_readdata = 32'h0;
  logic         master_readdatavalid = 1'b0;
  logic         master_waitrequest;

  localparam logic [163:0] PUX_EXP = {32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 4'hA};
  localparam logic [163:0] PUY_EXP = {32'h26, 32'h27, 32'h28, 32'h29, 32'h2A, 4'hB};

  ecc_csr_master #(.POLL_LIMIT(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .k                    (k),
    .px                   (px),
    .py                   (py),
    .pux                  (pux),
    .puy                  (puy),
    .busy                 (busy),
    .done                 (done),
    .timeout              (timeout),
    .state_dbg            (state_dbg),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model knobs (written by the stimulus process only)
  int wait_n = 0;
  int done_after = 0;
  bit stray_en = 1'b0;
  int stray_at = 0;

  // slave model state (written by the slave process only)
  logic [25:0] wr_addr [512];
  logic [31:0] wr_data [512];
  logic [25:0] rd_addr [512];
  int wr_n = 0, rd_n = 0, wcnt = 0, poll_n = 0, viol = 0;
  bit hold_prev = 1'b0, stray_arm = 1'b0, w_prev = 1'b0, r_prev = 1'b0;
  logic [25:0] a_prev = '0;
  logic [31:0] d_prev = '0;
  int done_cnt = 0, to_cnt = 0;

  assign master_waitrequest = (master_write || master_read) && (wcnt < wait_n);

  function automatic logic [31:0] slave_word(input logic [25:0] a, input int pn);
    int i;
    i = int'(a >> 2);
    if (i == 0) return {(done_after != 0 && pn + 1 >= done_after), 30'h0, 1'b1};
    case (i)
      25:      return 32'hA000_0000;
      31:      return 32'hB000_002B;
      default: return 32'(32'h20 + i - 20);
    endcase
  endfunction

  always @(posedge clk) begin
    master_readdatavalid <= 1'b0;
    if (start) poll_n <= 0;
    if (!reset_n) begin
      wcnt      <= 0;
      hold_prev <= 1'b0;
      stray_arm <= 1'b0;
    end else begin
      if (master_write && master_read) viol <= viol + 1;
      if (hold_prev && (master_address != a_prev || master_writedata != d_prev ||
                        master_write != w_prev || master_read != r_prev)) viol <= viol + 1;
      hold_prev <= (master_write || master_read) && master_waitrequest;
      a_prev    <= master_address;
      d_prev    <= master_writedata;
      w_prev    <= master_write;
      r_prev    <= master_read;
      if (stray_arm) begin
        master_readdatavalid <= 1'b1;
        master_readdata      <= 32'hFFFF_FFFF;
        stray_arm            <= 1'b0;
      end
      if ((master_write || master_read) && master_waitrequest) begin
        wcnt <= wcnt + 1;
      end else if (master_write) begin
        wcnt          <= 0;
        wr_addr[wr_n] <= master_address;
        wr_data[wr_n] <= master_writedata;
        wr_n          <= wr_n + 1;
        if (stray_en && wr_n == stray_at) stray_arm <= 1'b1;
      end else if (master_read) begin
        wcnt                 <= 0;
        rd_addr[rd_n]        <= master_address;
        rd_n                 <= rd_n + 1;
        master_readdatavalid <= 1'b1;
        master_readdata      <= slave_word(master_address, poll_n);
        if (master_address == 26'h0) poll_n <= poll_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (timeout) to_cnt <= to_cnt + 1;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] opw [1:18];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [163:0] op_of(input int b);
    return {opw[b], opw[b+1], opw[b+2], opw[b+3], opw[b+4], opw[b+5][31:28]};
  endfunction

  task automatic set_ops(input int mode);
    for (int i = 1; i <= 18; i++) begin
      if (i % 6 == 0)     opw[i] = {4'(i + mode), 28'h0};
      else if (mode == 0) opw[i] = 32'(32'h0101_0101 * i);
      else                opw[i] = ~32'(32'h0101_0101 * i);
    end
  endtask

  task automatic check_log(input string tag, input int wb, input int rb, input int polls, input bit to);
    logic [57:0] exp_q[$];
    logic [25:0] rexp_q[$];
    for (int i = 1; i <= 18; i++) exp_q.push_back({26'(4 * i), opw[i]});
    exp_q.push_back({26'h0, 32'h1});
    exp_q.push_back({26'h0, 32'h0});
    for (int i = 0; i < polls; i++) rexp_q.push_back(26'h0);
    if (!to) for (int i = 20; i <= 31; i++) rexp_q.push_back(26'(4 * i));
    check({tag, "_wr_count"}, 192'(wr_n - wb), 192'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {wr_addr[wb + i], wr_data[wb + i]}, exp_q[i]);
    check({tag, "_rd_count"}, 192'(rd_n - rb), 192'(rexp_q.size()));
    for (int i = 0; i < rexp_q.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_addr[rb + i], rexp_q[i]);
  endtask

  // driver: one full run using the operands in opw, then log/result checks
  task automatic do_case(input string tag, input bit extra, input int polls, input bit to,
                         input logic [163:0] exp_x, input logic [163:0] exp_y);
    int wb, rb, d0, t0;
    bit gd, gt;
    wb = wr_n; rb = rd_n; d0 = done_cnt; t0 = to_cnt;
    gd = 1'b0; gt = 1'b0;
    @(negedge clk);
    k = op_of(1); py = op_of(7); px = op_of(13); start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) gd = 1'b1;
      if (timeout) gt = 1'b1;
      if (gd || gt) break;
      start = extra && (c == 8);
      if (start) k = '1;
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, "_finished"}, gd | gt, 1);
    check({tag, "_done_seen"}, gd, !to);
    check({tag, "_timeout_seen"}, gt, to);
    check({tag, "_done_pulses"}, 192'(done_cnt - d0), to ? 0 : 1);
    check({tag, "_timeout_pulses"}, 192'(to_cnt - t0), to ? 1 : 0);
    check({tag, "_busy_after"}, busy, 0);
    check_log(tag, wb, rb, polls, to);
    check({tag, "_pux"}, pux, exp_x);
    check({tag, "_puy"}, puy, exp_y);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; start = 1'b0; k = '0; px = '0; py = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_write", master_write, 0);
    check("rst_read", master_read, 0);
    check("rst_addr", master_address, 0);
    check("rst_pux", pux, 0);
    check("rst_state", state_dbg, S_IDLE);
    reset_n = 1'b1;
    @(negedge clk);

    // k=1, zero-wait, done on the third poll
    for (int i = 1; i <= 18; i++) opw[i] = 32'h0;
    opw[6] = 32'h1000_0000;
    wait_n = 0; done_after = 3;
    do_case("t1", 1'b0, 3, 1'b0, PUX_EXP, PUY_EXP);

    // five wait states per access, with an ignored start while busy
    set_ops(0);
    wait_n = 5; done_after = 1;
    do_case("t2", 1'b1, 1, 1'b0, PUX_EXP, PUY_EXP);
    check("t2_stable", 192'(viol), 0);

    // stray readdatavalid during operand writes
    set_ops(1);
    wait_n = 0; done_after = 2; stray_en = 1'b1; stray_at = wr_n + 2;
    do_case("t3", 1'b0, 2, 1'b0, PUX_EXP, PUY_EXP);
    stray_en = 1'b0;

    // done never set: four polls then timeout, results unchanged
    set_ops(0);
    done_after = 0;
    do_case("t4", 1'b0, 4, 1'b1, PUX_EXP, PUY_EXP);

    // reset while a poll read is stalled in POLL_WAIT
    wait_n = 3; done_after = 0;
    @(negedge clk);
    k = op_of(1); py = op_of(7); px = op_of(13); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (state_dbg == S_POLL_WAIT && master_read) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_poll", found, 1);
    reset_n = 1'b0;
    #1;
    check("t5_read_drop", master_read, 0);
    check("t5_write_drop", master_write, 0);
    check("t5_busy_drop", busy, 0);
    check("t5_state", state_dbg, S_IDLE);
    check("t5_pux_cleared", pux, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_n = 0; done_after = 2;
    set_ops(1);
    do_case("t6", 1'b0, 2, 1'b0, PUX_EXP, PUY_EXP);

    check("bus_protocol", 192'(viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
